mem_lsu: RTL and testbench

Parametrised memory stage for the five-stage MIPS pipeline, placed between the EX/MEM and MEM/WB registers. It forwards the register-write and HI/LO results like a plain memory stage. It also performs byte, halfword and word loads and stores over a request/acknowledge data bus, and stalls the pipeline while an access is outstanding. It flags misaligned accesses and bus timeouts as exceptions and suppresses the write-back of the faulting instruction.

---
 rtl/mem_lsu.sv | 245 ++++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: MIPS MEM stage; forwards ALU/HI-LO results and runs byte/half/word loads and stores on a req/ack bus.
// Latency: zero for non-memory ops; memory ops take IDLE + WAIT (1..TIMEOUT cycles) + DONE.
// Backpressure: stall_req_o holds the pipeline from issue until the access resolves (ack or timeout).
module mem_lsu #(
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 16,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [31:0]           wdata_i,
  input  logic [31:0]           hi_i,
  input  logic [31:0]           lo_i,
  input  logic                  whilo_i,
  input  logic [3:0]            mem_op_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           mem_sdata_i,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [31:0]           bus_addr_o,
  output logic [3:0]            bus_sel_o,
  output logic [31:0]           bus_wdata_o,
  input  logic [31:0]           bus_rdata_i,
  input  logic                  bus_ack_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  output logic [31:0]           hi_o,
  output logic [31:0]           lo_o,
  output logic                  whilo_o,
  output logic                  stall_req_o,
  output logic                  align_exc_o,
  output logic                  timeout_exc_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter is 8 bits wide because TIMEOUT is limited to 1..255.
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic        to_q;
  logic [31:0] rdata_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  bus_sel_q;
  logic [31:0] bus_wdata_q;

  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        sz_byte;
  logic        sz_half;
  logic        sz_word;
  logic        sign_ext;
  logic        misalign;

  logic [1:0]  byte_lane;   // lane 0 = bits [7:0]
  logic        half_lane;   // 1 = bits [31:16]
  logic [3:0]  sel_d;
  logic [31:0] wdata_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  // Decode the memory opcode into direction, access size and extension mode.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sz_byte  = 1'b0;
    sz_half  = 1'b0;
    sz_word  = 1'b0;
    sign_ext = 1'b0;
    case (mem_op_i)
      4'd1: begin is_load  = 1'b1; sz_byte = 1'b1; sign_ext = 1'b1; end
      4'd2: begin is_load  = 1'b1; sz_byte = 1'b1; end
      4'd3: begin is_load  = 1'b1; sz_half = 1'b1; sign_ext = 1'b1; end
      4'd4: begin is_load  = 1'b1; sz_half = 1'b1; end
      4'd5: begin is_load  = 1'b1; sz_word = 1'b1; end
      4'd6: begin is_store = 1'b1; sz_byte = 1'b1; end
      4'd7: begin is_store = 1'b1; sz_half = 1'b1; end
      4'd8: begin is_store = 1'b1; sz_word = 1'b1; end
      default: ;
    endcase
  end

  assign is_mem   = is_load | is_store;
  assign misalign = (sz_half & mem_addr_i[0]) | (sz_word & (|mem_addr_i[1:0]));

  // Big-endian puts address offset 0 in the most significant lane.
  assign byte_lane = BIG_ENDIAN ? ~mem_addr_i[1:0] : mem_addr_i[1:0];
  assign half_lane = BIG_ENDIAN ? ~mem_addr_i[1]   : mem_addr_i[1];
  assign cnt_d     = cnt_q + 8'd1;

  // Byte-lane enables and lane-replicated store data for the request being issued.
  always_comb begin
    sel_d   = 4'b0000;
    wdata_d = mem_sdata_i;
    if (sz_byte) begin
      sel_d[byte_lane] = 1'b1;
      wdata_d          = {4{mem_sdata_i[7:0]}};
    end else if (sz_half) begin
      sel_d   = half_lane ? 4'b1100 : 4'b0011;
      wdata_d = {2{mem_sdata_i[15:0]}};
    end else if (sz_word) begin
      sel_d   = 4'b1111;
    end
  end

  // Pull the addressed byte/halfword out of the captured read word and extend it.
  always_comb begin
    case (byte_lane)
      2'd0:    ld_byte = rdata_q[7:0];
      2'd1:    ld_byte = rdata_q[15:8];
      2'd2:    ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
    ld_half = half_lane ? rdata_q[31:16] : rdata_q[15:0];
    ld_val  = rdata_q;
    if (sz_byte) begin
      ld_val = sign_ext ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
    end else if (sz_half) begin
      ld_val = sign_ext ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
    end
  end

  // Access FSM: issues the registered bus request, waits for ack or timeout, then retires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      to_q        <= 1'b0;
      rdata_q     <= 32'd0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_sel_q   <= 4'd0;
      bus_wdata_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (is_mem && !misalign) begin
            state_q     <= ST_WAIT;
            cnt_q       <= 8'd0;
            to_q        <= 1'b0;
            bus_req_q   <= 1'b1;
            bus_we_q    <= is_store;
            bus_addr_q  <= {mem_addr_i[31:2], 2'b00};
            bus_sel_q   <= sel_d;
            bus_wdata_q <= wdata_d;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_d;
          // An ack on the final allowed cycle still completes normally.
          if (bus_ack_i || (cnt_d == TIMEOUT_C)) begin
            state_q     <= ST_DONE;
            to_q        <= ~bus_ack_i;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_sel_q   <= 4'd0;
            bus_wdata_q <= 32'd0;
            if (bus_ack_i) begin
              rdata_q <= bus_rdata_i;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          cnt_q   <= 8'd0;
          to_q    <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_wdata_o = bus_wdata_q;

  // Result path toward MEM/WB: pass-through, with write-back suppressed while stalled or faulting.
  always_comb begin
    wd_o          = '0;
    wreg_o        = 1'b0;
    wdata_o       = 32'd0;
    hi_o          = 32'd0;
    lo_o          = 32'd0;
    whilo_o       = 1'b0;
    stall_req_o   = 1'b0;
    align_exc_o   = 1'b0;
    timeout_exc_o = 1'b0;
    if (rst) begin
      wd_o    = wd_i;
      wreg_o  = wreg_i;
      wdata_o = wdata_i;
      hi_o    = hi_i;
      lo_o    = lo_i;
      whilo_o = whilo_i;
      case (state_q)
        ST_IDLE: begin
          if (misalign) begin
            align_exc_o = 1'b1;
            wreg_o      = 1'b0;
            whilo_o     = 1'b0;
          end else if (is_mem) begin
            stall_req_o = 1'b1;
            wreg_o      = 1'b0;
            whilo_o     = 1'b0;
          end
        end
        ST_WAIT: begin
          stall_req_o = 1'b1;
          wreg_o      = 1'b0;
          whilo_o     = 1'b0;
        end
        ST_DONE: begin
          if (is_load) begin
            wdata_o = ld_val;
          end
          if (to_q) begin
            timeout_exc_o = 1'b1;
            wreg_o        = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed vectors against a big-endian and a little-endian instance (both TIMEOUT=4).
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: bus_ack_i is driven by the bench with a per-vector wait-cycle count.
module tb_mem_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i, hi_i, lo_i;
  logic        whilo_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i, mem_sdata_i, bus_rdata_i;
  logic        bus_ack_i;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic        req;
    logic        we;
    logic [31:0] baddr;
    logic [3:0]  sel;
    logic [31:0] bwdata;
    logic        stall;
    logic        align;
    logic        to;
  } dout_t;

  logic [4:0]  be_wd, le_wd;
  logic        be_wreg, le_wreg, be_whilo, le_whilo;
  logic [31:0] be_wdata, le_wdata, be_hi, le_hi, be_lo, le_lo;
  logic        be_req, le_req, be_we, le_we;
  logic [31:0] be_baddr, le_baddr, be_bwdata, le_bwdata;
  logic [3:0]  be_sel, le_sel;
  logic        be_stall, le_stall, be_align, le_align, be_to, le_to;
  dout_t       be_d, le_d;

  mem_lsu #(.REG_ADDR_W(5), .TIMEOUT(4), .BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i), .mem_op_i(mem_op_i),
    .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
    .bus_req_o(be_req), .bus_we_o(be_we), .bus_addr_o(be_baddr), .bus_sel_o(be_sel),
    .bus_wdata_o(be_bwdata), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .wd_o(be_wd), .wreg_o(be_wreg), .wdata_o(be_wdata), .hi_o(be_hi), .lo_o(be_lo),
    .whilo_o(be_whilo), .stall_req_o(be_stall), .align_exc_o(be_align), .timeout_exc_o(be_to)
  );

  mem_lsu #(.REG_ADDR_W(5), .TIMEOUT(4), .BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i), .mem_op_i(mem_op_i),
    .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
    .bus_req_o(le_req), .bus_we_o(le_we), .bus_addr_o(le_baddr), .bus_sel_o(le_sel),
    .bus_wdata_o(le_bwdata), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .wd_o(le_wd), .wreg_o(le_wreg), .wdata_o(le_wdata), .hi_o(le_hi), .lo_o(le_lo),
    .whilo_o(le_whilo), .stall_req_o(le_stall), .align_exc_o(le_align), .timeout_exc_o(le_to)
  );

  always_comb begin
    be_d = '0;
    be_d.wd = be_wd; be_d.wreg = be_wreg; be_d.wdata = be_wdata; be_d.hi = be_hi;
    be_d.lo = be_lo; be_d.whilo = be_whilo; be_d.req = be_req; be_d.we = be_we;
    be_d.baddr = be_baddr; be_d.sel = be_sel; be_d.bwdata = be_bwdata;
    be_d.stall = be_stall; be_d.align = be_align; be_d.to = be_to;
    le_d = '0;
    le_d.wd = le_wd; le_d.wreg = le_wreg; le_d.wdata = le_wdata; le_d.hi = le_hi;
    le_d.lo = le_lo; le_d.whilo = le_whilo; le_d.req = le_req; le_d.we = le_we;
    le_d.baddr = le_baddr; le_d.sel = le_sel; le_d.bwdata = le_bwdata;
    le_d.stall = le_stall; le_d.align = le_align; le_d.to = le_to;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Single-cycle IDLE vectors: pass-through and misaligned ops.
  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic        exp_wreg;
    logic        exp_whilo;
    logic        exp_align;
  } cvec_t;

  // Full bus transactions; val is the load result, or the lane data for stores.
  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    int          dly;
    logic [3:0]  be_sel;
    logic [3:0]  le_sel;
    logic [31:0] be_val;
    logic [31:0] le_val;
  } avec_t;

  typedef struct {
    int          stall;
    int          to_cnt;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [31:0] done_wdata;
    logic        done_wreg;
    logic        done_to;
    logic        done_seen;
    logic        stall_wreg;
    logic        post_req;
  } obs_t;

  task automatic upd(inout obs_t o, input dout_t d, input bit is_done);
    if (d.stall) o.stall++;
    if (d.stall && d.wreg) o.stall_wreg = 1'b1;
    if (d.to) o.to_cnt++;
    if (is_done) begin
      o.done_seen  = 1'b1;
      o.done_wdata = d.wdata;
      o.done_wreg  = d.wreg;
      o.done_to    = d.to;
    end else if (d.req) begin
      o.sel    = d.sel;
      o.we     = d.we;
      o.baddr  = d.baddr;
      o.bwdata = d.bwdata;
    end
  endtask

  // dly = WAIT cycles before ack (0 = ack on the first WAIT cycle), negative = never ack.
  task automatic run_access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                            input int dly, output obs_t ob, output obs_t ol);
    int w;
    ob = '{default: '0};
    ol = '{default: '0};
    @(posedge clk); #1;
    mem_op_i = op; mem_addr_i = addr; mem_sdata_i = data; bus_rdata_i = data;
    wdata_i = 32'h5555AAAA; wreg_i = 1'b1; whilo_i = 1'b1; wd_i = 5'd10; bus_ack_i = 1'b0;
    @(negedge clk);
    upd(ob, be_d, 1'b0); upd(ol, le_d, 1'b0);
    w = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (be_d.req) begin
        w++;
        upd(ob, be_d, 1'b0); upd(ol, le_d, 1'b0);
        if (dly >= 0 && w == dly + 1) bus_ack_i = 1'b1;
      end else begin
        upd(ob, be_d, 1'b1); upd(ol, le_d, 1'b1);
        bus_ack_i = 1'b0;
        break;
      end
    end
    bus_ack_i = 1'b0;
    @(posedge clk); #1;
    mem_op_i = 4'd0;
    @(negedge clk);
    if (be_d.to) ob.to_cnt++;
    if (le_d.to) ol.to_cnt++;
    ob.post_req = be_d.req;
    ol.post_req = le_d.req;
  endtask

  task automatic chk_acc(input string tag, input obs_t o, input logic [3:0] esel,
                         input logic [31:0] eval, input int estall, input bit est,
                         input logic [31:0] eaddr);
    chk({tag, "_done_seen"}, 32'(o.done_seen), 32'd1);
    chk({tag, "_stall_cycles"}, 32'(o.stall), 32'(estall));
    chk({tag, "_sel"}, 32'(o.sel), 32'(esel));
    chk({tag, "_we"}, 32'(o.we), 32'(est));
    chk({tag, "_bus_addr"}, o.baddr, eaddr);
    if (est) begin
      chk({tag, "_bus_wdata"}, o.bwdata, eval);
      chk({tag, "_done_wdata"}, o.done_wdata, 32'h5555AAAA);
    end else begin
      chk({tag, "_done_wdata"}, o.done_wdata, eval);
    end
    chk({tag, "_done_wreg"}, 32'(o.done_wreg), 32'd1);
    chk({tag, "_timeout_cnt"}, 32'(o.to_cnt), 32'd0);
    chk({tag, "_wreg_in_stall"}, 32'(o.stall_wreg), 32'd0);
    chk({tag, "_req_after"}, 32'(o.post_req), 32'd0);
  endtask

  cvec_t cv[7];
  avec_t av[10];
  obs_t  ob, ol;
  dout_t d;
  string pfx;

  initial begin
    cv[0] = '{4'd0,  32'h0000_0000, 5'd3,  1'b1, 32'h0000_1234, 1'b1, 1'b1, 1'b1, 1'b0};
    cv[1] = '{4'd5,  32'h0000_0006, 5'd7,  1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0, 1'b1};
    cv[2] = '{4'd3,  32'h0000_0101, 5'd9,  1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b1};
    cv[3] = '{4'd7,  32'h0000_0003, 5'd1,  1'b0, 32'h0000_0003, 1'b1, 1'b0, 1'b0, 1'b1};
    cv[4] = '{4'd8,  32'h0000_0002, 5'd31, 1'b1, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 1'b1};
    cv[5] = '{4'd12, 32'h0000_0007, 5'd4,  1'b1, 32'h0000_0005, 1'b1, 1'b1, 1'b1, 1'b0};
    cv[6] = '{4'd4,  32'h0000_0001, 5'd6,  1'b1, 32'h0000_0006, 1'b1, 1'b0, 1'b0, 1'b1};

    av[0] = '{4'd1, 32'h101, 32'h1180_2233, 0, 4'b0100, 4'b0010, 32'hFFFF_FF80, 32'h0000_0022};
    av[1] = '{4'd2, 32'h101, 32'h1180_2233, 0, 4'b0100, 4'b0010, 32'h0000_0080, 32'h0000_0022};
    av[2] = '{4'd3, 32'h100, 32'h8001_F00F, 1, 4'b1100, 4'b0011, 32'hFFFF_8001, 32'hFFFF_F00F};
    av[3] = '{4'd4, 32'h102, 32'h8001_F00F, 0, 4'b0011, 4'b1100, 32'h0000_F00F, 32'h0000_8001};
    av[4] = '{4'd5, 32'h104, 32'hDEAD_BEEF, 2, 4'b1111, 4'b1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    av[5] = '{4'd1, 32'h203, 32'h1122_33F4, 0, 4'b0001, 4'b1000, 32'hFFFF_FFF4, 32'h0000_0011};
    av[6] = '{4'd2, 32'h200, 32'h9A00_0000, 3, 4'b1000, 4'b0001, 32'h0000_009A, 32'h0000_0000};
    av[7] = '{4'd7, 32'h202, 32'h1234_ABCD, 0, 4'b0011, 4'b1100, 32'hABCD_ABCD, 32'hABCD_ABCD};
    av[8] = '{4'd6, 32'h001, 32'hFFFF_FF5A, 1, 4'b0100, 4'b0010, 32'h5A5A_5A5A, 32'h5A5A_5A5A};
    av[9] = '{4'd8, 32'h008, 32'hCAFE_F00D, 0, 4'b1111, 4'b1111, 32'hCAFE_F00D, 32'hCAFE_F00D};

    // Reset: every output forced low even with live inputs.
    rst = 1'b0;
    wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h1234; hi_i = 32'h11; lo_i = 32'h22; whilo_i = 1'b1;
    mem_op_i = 4'd0; mem_addr_i = 32'd0; mem_sdata_i = 32'd0; bus_rdata_i = 32'd0; bus_ack_i = 1'b0;
    #12;
    chk("reset_be_outputs_zero", 32'(be_d == '0), 32'd1);
    chk("reset_le_outputs_zero", 32'(le_d == '0), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;

    // Combinational IDLE vectors.
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      mem_op_i = cv[i].op; mem_addr_i = cv[i].addr; wd_i = cv[i].wd; wreg_i = cv[i].wreg;
      wdata_i = cv[i].wdata; whilo_i = cv[i].whilo;
      hi_i = 32'h1000_0000 + 32'(i); lo_i = 32'h2000_0000 + 32'(i);
      bus_ack_i = 1'b1;  // ignored in IDLE
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        d = (k == 0) ? be_d : le_d;
        pfx = $sformatf("cv%0d_%s", i, (k == 0) ? "be" : "le");
        chk({pfx, "_wd"}, 32'(d.wd), 32'(cv[i].wd));
        chk({pfx, "_wreg"}, 32'(d.wreg), 32'(cv[i].exp_wreg));
        chk({pfx, "_wdata"}, d.wdata, cv[i].wdata);
        chk({pfx, "_whilo"}, 32'(d.whilo), 32'(cv[i].exp_whilo));
        chk({pfx, "_hi"}, d.hi, 32'h1000_0000 + 32'(i));
        chk({pfx, "_lo"}, d.lo, 32'h2000_0000 + 32'(i));
        chk({pfx, "_stall"}, 32'(d.stall), 32'd0);
        chk({pfx, "_align"}, 32'(d.align), 32'(cv[i].exp_align));
      end
      @(negedge clk);
      chk($sformatf("cv%0d_be_req_after_edge", i), 32'(be_d.req), 32'd0);
      chk($sformatf("cv%0d_le_req_after_edge", i), 32'(le_d.req), 32'd0);
      chk($sformatf("cv%0d_be_stall_after_edge", i), 32'(be_d.stall), 32'd0);
      bus_ack_i = 1'b0;
    end
    @(posedge clk); #1;
    mem_op_i = 4'd0;

    // Load/store transactions.
    for (int i = 0; i < 10; i++) begin
      run_access(av[i].op, av[i].addr, av[i].data, av[i].dly, ob, ol);
      chk_acc($sformatf("av%0d_be", i), ob, av[i].be_sel, av[i].be_val, av[i].dly + 2,
              av[i].op >= 4'd6, {av[i].addr[31:2], 2'b00});
      chk_acc($sformatf("av%0d_le", i), ol, av[i].le_sel, av[i].le_val, av[i].dly + 2,
              av[i].op >= 4'd6, {av[i].addr[31:2], 2'b00});
    end

    // Reset in the middle of a WAIT.
    @(posedge clk); #1;
    mem_op_i = 4'd5; mem_addr_i = 32'h100; wd_i = 5'd2; wreg_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_be_req_in_wait", 32'(be_d.req), 32'd1);
    chk("rstmid_le_req_in_wait", 32'(le_d.req), 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rstmid_be_req_drop", 32'(be_d.req), 32'd0);
    chk("rstmid_le_req_drop", 32'(le_d.req), 32'd0);
    chk("rstmid_be_outputs_zero", 32'(be_d == '0), 32'd1);
    mem_op_i = 4'd0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_be_idle_stall", 32'(be_d.stall), 32'd0);
    chk("rstmid_be_idle_req", 32'(be_d.req), 32'd0);
    chk("rstmid_be_idle_wd", 32'(be_d.wd), 32'd2);

    // Timeout (TIMEOUT=4): follows the aborted access, so a stale counter would shorten it.
    run_access(4'd5, 32'h010, 32'h7777_7777, -1, ob, ol);
    chk("to_be_done_seen", 32'(ob.done_seen), 32'd1);
    chk("to_be_stall_cycles", 32'(ob.stall), 32'd5);
    chk("to_le_stall_cycles", 32'(ol.stall), 32'd5);
    chk("to_be_exc_in_done", 32'(ob.done_to), 32'd1);
    chk("to_be_exc_pulses", 32'(ob.to_cnt), 32'd1);
    chk("to_le_exc_pulses", 32'(ol.to_cnt), 32'd1);
    chk("to_be_done_wreg", 32'(ob.done_wreg), 32'd0);
    chk("to_be_wreg_in_stall", 32'(ob.stall_wreg), 32'd0);
    chk("to_be_req_after", 32'(ob.post_req), 32'd0);

    // Normal access after reset and timeout.
    run_access(4'd5, 32'h104, 32'h0BAD_F00D, 0, ob, ol);
    chk_acc("post_be", ob, 4'b1111, 32'h0BAD_F00D, 2, 1'b0, 32'h104);
    chk_acc("post_le", ol, 4'b1111, 32'h0BAD_F00D, 2, 1'b0, 32'h104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
